// File: rtl/ontransit_pkg.sv
// Shared definitions for the on-transit FSM family: state encoding and default widths.
package ontransit_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAST  = 2'd3
  } state_t;

endpackage

// File: rtl/burst_beat_ctr.sv
// Burst bookkeeping: remaining-beat down-counter and issued-beat up-counter,
// both steered by single-cycle load/clear/dec strobes from the sequencer FSM.
module burst_beat_ctr
  import ontransit_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] rem,
  output logic [CNT_W-1:0] beat_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      rem      <= len;
      beat_cnt <= '0;
    end else if (clear) begin
      rem      <= '0;
      beat_cnt <= '0;
    end else if (dec) begin
      rem      <= rem - 1'b1;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ontransit_burst_seq.sv
// Burst sequencer: one registered step pulse per beat, with stall, abort,
// zero-length bursts and a one-cycle LAST cooldown before the next request.
module ontransit_burst_seq
  import ontransit_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             hold,
  input  logic             abort,
  output logic             step,
  output logic             done,
  output logic             aborted,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  state_t           state, nx_state;
  logic             nx_step, nx_done, nx_aborted, nx_busy;
  logic             ctr_load, ctr_clear, ctr_dec;
  logic [CNT_W-1:0] rem;

  burst_beat_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .clear    (ctr_clear),
    .dec      (ctr_dec),
    .len      (len),
    .rem      (rem),
    .beat_cnt (beat_cnt)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nx_state   = state;
    nx_step    = 1'b0;
    nx_done    = 1'b0;
    nx_aborted = 1'b0;
    ctr_load   = 1'b0;
    ctr_clear  = 1'b0;
    ctr_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            nx_state = RUN;
            ctr_load = 1'b1;
          end else begin
            nx_state  = LAST;
            nx_done   = 1'b1;
            ctr_clear = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          nx_state   = LAST;
          nx_aborted = 1'b1;
        end else if (hold) begin
          nx_state = PAUSE;
        end else begin
          nx_step = 1'b1;
          ctr_dec = 1'b1;
          if (rem == CNT_W'(1)) begin
            nx_done  = 1'b1;
            nx_state = LAST;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          nx_state   = LAST;
          nx_aborted = 1'b1;
        end else if (!hold) begin
          nx_state = RUN;
        end
      end
      LAST:    nx_state = IDLE;
      default: nx_state = IDLE;
    endcase
    nx_busy = (nx_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nx_state;
      step    <= nx_step;
      done    <= nx_done;
      aborted <= nx_aborted;
      busy    <= nx_busy;
    end
  end

`ifndef SYNTHESIS
  // Readable state label for waveform viewers and debug prints.
  function automatic string state_name(state_t s);
    case (s)
      IDLE:    return "IDLE";
      RUN:     return "RUN";
      PAUSE:   return "PAUSE";
      LAST:    return "LAST";
      default: return "UNKNOWN";
    endcase
  endfunction
`endif

endmodule

// File: tb/tb_ontransit_burst_seq.sv
// Scoreboard bench for ontransit_burst_seq: directed bursts from the test plan,
// then randomized bursts with stalls, aborts and ignored start requests.
module tb_ontransit_burst_seq;

  localparam int CNT_W = 8;
  localparam int MAXC  = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             step, done, aborted, busy;
  logic [CNT_W-1:0] beat_cnt;

  ontransit_burst_seq #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .hold     (hold),
    .abort    (abort),
    .step     (step),
    .done     (done),
    .aborted  (aborted),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    bit st;
    bit dn;
    bit ab;
    int bc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad = 0;
  bit  hold_a[MAXC];
  bit  abort_a[MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (rst_n && (step || done || aborted)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, step, done, aborted}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_kind", {29'd0, step, done, aborted}, {29'd0, mon_e.st, mon_e.dn, mon_e.ab});
        check("pulse_beat_cnt", beat_cnt, mon_e.bc);
        check("pulse_busy", busy, 1);
      end
    end
  end

  // Reference model: cycle 0 is the cycle start is presented; inputs in cycle k
  // take effect in cycle k+1. Beats are consumed one per unstalled cycle; a stall
  // lasts while hold stays high and its release costs one more idle cycle.
  task automatic ref_model(input int L, input int T, output int last_busy, output int cnt);
    int rem;
    bit paused;
    cnt = 0;
    last_busy = 0;
    if (L == 0) begin
      exp_q.push_back('{T + 1, 1'b0, 1'b1, 1'b0, 0});
      last_busy = 1;
      return;
    end
    rem = L;
    paused = 1'b0;
    for (int k = 1; k < MAXC - 1; k++) begin
      if (abort_a[k]) begin
        exp_q.push_back('{T + k + 1, 1'b0, 1'b0, 1'b1, cnt});
        last_busy = k + 1;
        return;
      end
      if (paused) paused = hold_a[k];
      else if (hold_a[k]) paused = 1'b1;
      else begin
        rem--;
        cnt++;
        exp_q.push_back('{T + k + 1, 1'b1, rem == 0, 1'b0, cnt});
        if (rem == 0) begin
          last_busy = k + 1;
          return;
        end
      end
    end
  endtask

  // noise: 0 = start low after acceptance, 1 = random start/len while busy,
  // 2 = start held high throughout (back-to-back).
  task automatic run_burst(input int L, input bit rnd, input int hs, input int hl,
                           input int ac, input int noise, input int gap);
    int T, lb, cnt;
    for (int k = 0; k < MAXC; k++) begin
      if (rnd) begin
        hold_a[k]  = (k < 2 * L + 4) && ($urandom_range(0, 4) == 0);
        abort_a[k] = ($urandom_range(0, 4 * L + 20) == 0);
      end else begin
        hold_a[k]  = (k >= hs) && (k < hs + hl);
        abort_a[k] = (k == ac);
      end
    end
    T = cyc;
    ref_model(L, T, lb, cnt);
    for (int k = 0; k <= lb; k++) begin
      if (k == 0) begin
        start = 1'b1;
        len   = L[CNT_W-1:0];
      end else begin
        check("busy_in_burst", busy, 1);
        if (noise == 2) start = 1'b1;
        else if (noise == 1) begin
          start = 1'($urandom_range(0, 1));
          len   = CNT_W'($urandom);
        end else start = 1'b0;
      end
      hold  = hold_a[k];
      abort = abort_a[k];
      @(posedge clk);
      #1;
    end
    check("idle_busy", busy, 0);
    check("idle_beat_cnt", beat_cnt, cnt);
    check("scoreboard_drained", exp_q.size(), 0);
    for (int g = 0; g < gap; g++) begin
      start = 1'b0;
      hold  = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("idle_keep_beat_cnt", beat_cnt, cnt);
      check("idle_keep_busy", busy, 0);
    end
  endtask

  initial begin
    int T;
    #12;
    check("reset_step", step, 0);
    check("reset_done", done, 0);
    check("reset_aborted", aborted, 0);
    check("reset_busy", busy, 0);
    check("reset_beat_cnt", beat_cnt, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_burst(4, 1'b0, -1, 0, -1, 0, 1);   // plain len=4
    run_burst(0, 1'b0, -1, 0, -1, 0, 1);   // zero-length
    run_burst(5, 1'b0, 3, 3, -1, 0, 1);    // 3-cycle hold after the 2nd step
    run_burst(6, 1'b0, -1, 0, 4, 0, 1);    // abort after the 3rd step
    run_burst(2, 1'b0, -1, 0, -1, 2, 0);   // back-to-back, start never drops
    run_burst(2, 1'b0, -1, 0, -1, 2, 0);
    run_burst(2, 1'b0, -1, 0, -1, 2, 1);
    run_burst(3, 1'b0, 2, 2, 3, 0, 1);     // abort while paused
    run_burst(3, 1'b0, 2, 1, 2, 0, 1);     // abort together with hold
    run_burst(3, 1'b0, -1, 0, 3, 0, 1);    // abort on the final beat
    run_burst(1, 1'b0, -1, 0, 0, 1, 2);    // single beat, abort with start in IDLE
    run_burst(255, 1'b0, -1, 0, -1, 0, 1); // maximum length
    for (int i = 0; i < 40; i++)
      run_burst($urandom_range(0, 20), 1'b1, 0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 2));

    // Reset in the middle of a len=8 burst, after two steps.
    T = cyc;
    start = 1'b1;
    len   = 8'd8;
    hold  = 1'b0;
    abort = 1'b0;
    exp_q.push_back('{T + 2, 1'b1, 1'b0, 1'b0, 1});
    exp_q.push_back('{T + 3, 1'b1, 1'b0, 1'b0, 2});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_step", step, 0);
    check("midrst_done", done, 0);
    check("midrst_aborted", aborted, 0);
    check("midrst_busy", busy, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
    check("midrst_drained", exp_q.size(), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = 1'b0;
      hold  = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("postrst_busy", busy, 0);
      check("postrst_step", step, 0);
      check("postrst_beat_cnt", beat_cnt, 0);
    end

    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
